// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter that shares one parallel-write buffer port among NREQ producers.
// Each accepted block gets one WRITE cycle and then one HOLD cycle so the buffer can update ready.
module buffer_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int PW    = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*PW*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     buf_ready,
  output logic                     buf_wEn,
  output logic [PW*WIDTH-1:0]      buf_in,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic [15:0]              write_count
);

  localparam int BW = PW * WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  ptr_reg, ptr_next;
  logic [NREQ-1:0] gnt_next;
  logic            wen_next;
  logic            busy_next;
  logic [BW-1:0]   buf_in_next;
  logic [IDW-1:0]  grant_id_next;
  logic [15:0]     write_count_next;

  logic [BW-1:0]   slice [NREQ];
  logic            found;
  logic [IDW-1:0]  winner;
  int              idx;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*BW +: BW];
    end
  endgenerate

  // First requester at or after (last winner + 1), wrapping at NREQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    gnt_next         = '0;
    wen_next         = 1'b0;
    busy_next        = 1'b0;
    buf_in_next      = buf_in;
    grant_id_next    = grant_id;
    write_count_next = write_count;
    case (state_reg)
      IDLE: begin
        if (found && buf_ready) begin
          state_next       = WRITE;
          ptr_next         = winner;
          grant_id_next    = winner;
          buf_in_next      = slice[winner];
          gnt_next[winner] = 1'b1;
          wen_next         = 1'b1;
          busy_next        = 1'b1;
          // Count becomes visible together with the wEn pulse it describes
          write_count_next = write_count + 16'd1;
        end
      end
      WRITE: begin
        state_next = HOLD;
        busy_next  = 1'b1;
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= IDW'(NREQ - 1);
      gnt         <= '0;
      buf_wEn     <= 1'b0;
      busy        <= 1'b0;
      buf_in      <= '0;
      grant_id    <= '0;
      write_count <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt         <= gnt_next;
      buf_wEn     <= wen_next;
      busy        <= busy_next;
      buf_in      <= buf_in_next;
      grant_id    <= grant_id_next;
      write_count <= write_count_next;
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter, including a small behavioural model of
// an 8-deep, 4-wide circular buffer for the back-pressure integration sequence.
module tb_buffer_write_arbiter;

  localparam int WIDTH = 16;
  localparam int PW    = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BW    = PW * WIDTH;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*BW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 ready_tb;
  logic                 buf_ready;
  logic                 buf_wEn;
  logic [BW-1:0]        buf_in;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic [15:0]          write_count;

  // Behavioural buffer model (write side only, no reads)
  logic                 use_model;
  logic                 cb_clear;
  int                   cb_count;
  logic                 model_ready;
  assign model_ready = (DEPTH - cb_count) >= PW;
  assign buf_ready   = use_model ? model_ready : ready_tb;

  always @(posedge clk) begin
    if (cb_clear) cb_count <= 0;
    else if (buf_wEn && cb_count <= DEPTH - PW) cb_count <= cb_count + PW;
  end

  int vectors = 0;
  int misses  = 0;

  buffer_write_arbiter #(.WIDTH(WIDTH), .PW(PW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .buf_ready   (buf_ready),
    .buf_wEn     (buf_wEn),
    .buf_in      (buf_in),
    .busy        (busy),
    .grant_id    (grant_id),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_block(input int i, input logic [BW-1:0] blk);
    req_data[i*BW +: BW] = blk;
  endtask

  localparam logic [BW-1:0] DATA0 = {16'd12, 16'd8, 16'd1, 16'd5};
  localparam logic [BW-1:0] DATA2 = {16'd120, 16'd130, 16'd150, 16'd170};

  int wen_seen;
  logic [15:0] wc_before;

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    ready_tb  = 1'b0;
    use_model = 1'b0;
    cb_clear  = 1'b1;
    tick();
    tick();
    check("reset_wen", 64'(buf_wEn), 64'd0);
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_count", 64'(write_count), 64'd0);
    rst = 1'b0;

    // First write from requester 0
    set_block(0, DATA0);
    req      = 4'b0001;
    ready_tb = 1'b1;
    tick();
    $display("txn single: gnt=%b wEn=%0b data=%h count=%0d", gnt, buf_wEn, buf_in, write_count);
    check("single_wen", 64'(buf_wEn), 64'd1);
    check("single_gnt", 64'(gnt), 64'b0001);
    check("single_data", buf_in, DATA0);
    check("single_count", 64'(write_count), 64'd1);
    check("single_busy", 64'(busy), 64'd1);
    req = '0;
    tick();
    check("hold_wen", 64'(buf_wEn), 64'd0);
    check("hold_gnt", 64'(gnt), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a cycle clears outputs immediately
    #3 rst = 1'b1;
    #1;
    $display("txn async reset: wEn=%0b data=%h count=%0d", buf_wEn, buf_in, write_count);
    check("arst_data", buf_in, 64'd0);
    check("arst_count", 64'(write_count), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;

    // Round robin from reset: 0,1,2,3,0 at 3-cycle spacing
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("txn rr %0d: gnt=%b id=%0d count=%0d", k, gnt, grant_id, write_count);
      check("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
      check("rr_id", 64'(grant_id), 64'(k % 4));
      check("rr_wen", 64'(buf_wEn), 64'd1);
      tick();
      check("rr_hold_gnt", 64'(gnt), 64'd0);
      tick();
      check("rr_idle_wen", 64'(buf_wEn), 64'd0);
    end
    check("rr_count", 64'(write_count), 64'd5);
    req = '0;

    // Back-pressure: requester 2 waits while the buffer is not ready
    set_block(2, DATA2);
    ready_tb = 1'b0;
    req      = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_idle", 64'({buf_wEn, gnt}), 64'd0);
    end
    $display("txn backpressure: 10 idle cycles, raising ready");
    ready_tb = 1'b1;
    tick();
    $display("txn bp grant: gnt=%b data=%h", gnt, buf_in);
    check("bp_gnt", 64'(gnt), 64'b0100);
    check("bp_data", buf_in, DATA2);
    req = '0;
    set_block(2, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    check("bp_data_held", buf_in, DATA2);
    tick();

    // Skip and withdraw: move pointer to 0, then request 1 and 3
    req = 4'b0001;
    tick();
    check("skip_pre_gnt", 64'(gnt), 64'b0001);
    req = '0;
    tick();
    tick();
    req = 4'b1010;
    tick();
    $display("txn skip: gnt=%b id=%0d", gnt, grant_id);
    check("skip_gnt", 64'(gnt), 64'b0010);
    tick();
    req = '0;
    tick();
    tick();
    check("withdraw_gnt", 64'(gnt), 64'd0);
    check("withdraw_busy", 64'(busy), 64'd0);
    req = 4'b1111;
    tick();
    check("withdraw_ptr", 64'(gnt), 64'b0100);
    req = '0;
    tick();
    tick();

    // Reset during WRITE
    req = 4'b0001;
    tick();
    check("rstw_pre_wen", 64'(buf_wEn), 64'd1);
    #2 rst = 1'b1;
    #1;
    $display("txn reset in WRITE: wEn=%0b gnt=%b count=%0d", buf_wEn, gnt, write_count);
    check("rstw_wen", 64'(buf_wEn), 64'd0);
    check("rstw_gnt", 64'(gnt), 64'd0);
    check("rstw_count", 64'(write_count), 64'd0);
    req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    check("rstw_first_gnt", 64'(gnt), 64'b0001);
    req = '0;
    tick();
    tick();

    // Integration with buffer model: three producers, no reads
    cb_clear  = 1'b0;
    use_model = 1'b1;
    wc_before = write_count;
    wen_seen  = 0;
    req       = 4'b0111;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (buf_wEn) wen_seen++;
    end
    $display("txn integration: writes=%0d words=%0d ready=%0b", wen_seen, cb_count, model_ready);
    check("int_writes", 64'(wen_seen), 64'd2);
    check("int_words", 64'(cb_count), 64'(DEPTH));
    check("int_full", 64'(cb_count == DEPTH), 64'd1);
    check("int_count", 64'(write_count), 64'(wc_before + 16'd2));
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
